// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: W pipeline register, register-file write ports, halt FSM.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
    parameter int          DATA_W = 64,
    parameter int          CNT_W  = 32,
    parameter logic [3:0]  RNONE  = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_stall,
    input  logic              w_bubble,
    input  logic [2:0]        m_stat,
    input  logic [3:0]        m_icode,
    input  logic [3:0]        m_dstE,
    input  logic [DATA_W-1:0] m_valE,
    input  logic [3:0]        m_dstM,
    input  logic [DATA_W-1:0] m_valM,
    output logic              wr_e_en,
    output logic [3:0]        wr_e_addr,
    output logic [DATA_W-1:0] wr_e_data,
    output logic              wr_m_en,
    output logic [3:0]        wr_m_addr,
    output logic [DATA_W-1:0] wr_m_data,
    output logic [3:0]        W_dstE,
    output logic [DATA_W-1:0] W_valE,
    output logic [3:0]        W_dstM,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_icode,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);
    localparam logic [2:0] AOK   = 3'd1;
    localparam logic [3:0] INOP  = 4'h1;

    typedef enum logic {S_RUN, S_HALT} state_t;

    typedef struct packed {
        logic              valid;
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        dstE;
        logic [DATA_W-1:0] valE;
        logic [3:0]        dstM;
        logic [DATA_W-1:0] valM;
    } wreg_t;

    wreg_t  w_q, w_d, bubble_w;
    state_t state_q;
    logic   run, halt_now, can_wr;

    assign run      = (state_q == S_RUN);
    assign halt_now = w_q.valid && (w_q.stat != AOK);

    always_comb begin
        bubble_w       = '0;
        bubble_w.stat  = AOK;
        bubble_w.icode = INOP;
        bubble_w.dstE  = RNONE;
        bubble_w.dstM  = RNONE;
    end

    // A faulting instruction stays in W so its status remains visible once halted.
    always_comb begin
        w_d = w_q;
        if (run && !halt_now && !w_stall) begin
            if (w_bubble) begin
                w_d = bubble_w;
            end else begin
                w_d.valid = 1'b1;
                w_d.stat  = m_stat;
                w_d.icode = m_icode;
                w_d.dstE  = m_dstE;
                w_d.valE  = m_valE;
                w_d.dstM  = m_dstM;
                w_d.valM  = m_valM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= bubble_w;
            state_q <= S_RUN;
        end else begin
            w_q <= w_d;
            if (run && halt_now) state_q <= S_HALT;
        end
    end

    // When both ports target the same register the M write wins.
    assign can_wr    = run && w_q.valid && (w_q.stat == AOK);
    assign wr_m_en   = can_wr && (w_q.dstM != RNONE);
    assign wr_e_en   = can_wr && (w_q.dstE != RNONE) && !(wr_m_en && (w_q.dstE == w_q.dstM));
    assign wr_e_addr = w_q.dstE;
    assign wr_e_data = w_q.valE;
    assign wr_m_addr = w_q.dstM;
    assign wr_m_data = w_q.valM;

    assign W_dstE  = w_q.dstE;
    assign W_valE  = w_q.valE;
    assign W_dstM  = w_q.dstM;
    assign W_valM  = w_q.valM;
    assign W_icode = w_q.icode;
    assign stat    = w_q.valid ? w_q.stat : AOK;
    assign halted  = (state_q == S_HALT);

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (can_wr && !w_stall) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed checks plus randomized traffic
// compared every cycle against a behavioural model of the W stage.
module tb_writeback_stage;
    localparam int DATA_W = 64;
    localparam int CNT_W  = 4;
`ifdef WB_RETIRE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              w_stall = 1'b0, w_bubble = 1'b0;
    logic [2:0]        m_stat = 3'd1;
    logic [3:0]        m_icode = 4'h0, m_dstE = 4'hF, m_dstM = 4'hF;
    logic [DATA_W-1:0] m_valE = '0, m_valM = '0;
    logic              wr_e_en, wr_m_en, halted;
    logic [3:0]        wr_e_addr, wr_m_addr, W_dstE, W_dstM, W_icode;
    logic [DATA_W-1:0] wr_e_data, wr_m_data, W_valE, W_valM;
    logic [2:0]        stat;
    logic [CNT_W-1:0]  retired_cnt;

    int checks = 0, errors = 0;
    bit started = 1'b0;

    writeback_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RNONE(4'hF)) dut (
        .clk(clk), .rst(rst), .w_stall(w_stall), .w_bubble(w_bubble),
        .m_stat(m_stat), .m_icode(m_icode), .m_dstE(m_dstE), .m_valE(m_valE),
        .m_dstM(m_dstM), .m_valM(m_valM),
        .wr_e_en(wr_e_en), .wr_e_addr(wr_e_addr), .wr_e_data(wr_e_data),
        .wr_m_en(wr_m_en), .wr_m_addr(wr_m_addr), .wr_m_data(wr_m_data),
        .W_dstE(W_dstE), .W_valE(W_valE), .W_dstM(W_dstM), .W_valM(W_valM),
        .W_icode(W_icode), .stat(stat), .halted(halted), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the instruction sitting in W, whether the machine has stopped, and a count.
    bit          md_valid, md_halt;
    logic [2:0]  md_stat;
    logic [3:0]  md_icode, md_dstE, md_dstM;
    logic [63:0] md_valE, md_valM;
    int unsigned md_cnt;

    task automatic model_bubble();
        md_valid = 0; md_stat = 3'd1; md_icode = 4'h1;
        md_dstE = 4'hF; md_dstM = 4'hF; md_valE = 0; md_valM = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_bubble(); md_halt = 0; md_cnt = 0;
        end else if (!md_halt) begin
            if (md_valid && md_stat != 3'd1) begin
                md_halt = 1;
            end else begin
                if (md_valid && !w_stall) md_cnt = (md_cnt + 1) % (1 << CNT_W);
                if (w_stall) ;
                else if (w_bubble) model_bubble();
                else begin
                    md_valid = 1; md_stat = m_stat; md_icode = m_icode;
                    md_dstE = m_dstE; md_valE = m_valE; md_dstM = m_dstM; md_valM = m_valM;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            bit ok, exp_m, exp_e;
            ok    = !md_halt && md_valid && md_stat == 3'd1;
            exp_m = ok && md_dstM != 4'hF;
            exp_e = ok && md_dstE != 4'hF && !(exp_m && md_dstE == md_dstM);
            chk("wr_e_en", wr_e_en, exp_e);
            chk("wr_m_en", wr_m_en, exp_m);
            chk("wr_e_addr", wr_e_addr, md_dstE);
            chk("wr_e_data", wr_e_data, md_valE);
            chk("wr_m_addr", wr_m_addr, md_dstM);
            chk("wr_m_data", wr_m_data, md_valM);
            chk("W_icode", W_icode, md_icode);
            chk("stat", stat, md_valid ? md_stat : 3'd1);
            chk("halted", halted, md_halt);
            chk("retired_cnt", retired_cnt, CNT_EN ? md_cnt : 0);
        end
    end

    task automatic step(input logic [2:0] st, input logic [3:0] de, input logic [63:0] ve,
                        input logic [3:0] dm, input logic [63:0] vm,
                        input logic s, input logic b, input logic r);
        m_stat = st; m_icode = $urandom_range(0, 11); m_dstE = de; m_valE = ve;
        m_dstM = dm; m_valM = vm; w_stall = s; w_bubble = b; rst = r;
        @(posedge clk); #1;
    endtask

    initial begin
        #1;
        step(3'd1, 4'h2, 64'h9, 4'h7, 64'h8, 0, 0, 1);
        started = 1'b1;
        step(3'd1, 4'h2, 64'h9, 4'h7, 64'h8, 0, 0, 1);
        chk("rst_wr_e_en", wr_e_en, 0); chk("rst_wr_m_en", wr_m_en, 0);
        chk("rst_stat", stat, 1); chk("rst_halted", halted, 0);
        chk("rst_cnt", retired_cnt, 0);
        chk("rst_W_dstE", W_dstE, 4'hF); chk("rst_W_dstM", W_dstM, 4'hF);

        step(3'd1, 4'h3, 64'h55, 4'hF, 64'h0, 0, 0, 0);
        chk("e_only_en", wr_e_en, 1); chk("e_only_addr", wr_e_addr, 3);
        chk("e_only_data", wr_e_data, 64'h55); chk("e_only_m_en", wr_m_en, 0);

        step(3'd1, 4'h4, 64'h100, 4'h4, 64'hAA, 0, 0, 0);
        chk("cnt_first", retired_cnt, CNT_EN ? 1 : 0);
        chk("same_m_en", wr_m_en, 1); chk("same_m_addr", wr_m_addr, 4);
        chk("same_m_data", wr_m_data, 64'hAA); chk("same_e_en", wr_e_en, 0);

        for (int i = 0; i < 3; i++) step(3'd1, 4'h9, 64'h1, 4'h9, 64'h2, 1, 1, 0);
        chk("stall_W_dstM", W_dstM, 4); chk("stall_W_valM", W_valM, 64'hAA);
        chk("stall_cnt", retired_cnt, CNT_EN ? 1 : 0);
        step(3'd1, 4'h9, 64'h1, 4'h9, 64'h2, 0, 1, 0);
        chk("bubble_W_dstE", W_dstE, 4'hF); chk("bubble_stat", stat, 1);
        chk("bubble_cnt", retired_cnt, CNT_EN ? 2 : 0);

        step(3'd2, 4'h5, 64'h77, 4'hF, 64'h0, 0, 0, 0);
        chk("hlt_e_en", wr_e_en, 0); chk("hlt_halted_early", halted, 0);
        chk("hlt_stat_w", stat, 2);
        step(3'd1, 4'h6, 64'h12, 4'h6, 64'h34, 0, 0, 0);
        chk("hlt_halted", halted, 1); chk("hlt_stat", stat, 2);
        for (int i = 0; i < 4; i++) step(3'd1, 4'(i), 64'(i), 4'h8, 64'h5, 0, 0, 0);
        chk("hlt_frozen_dstE", W_dstE, 5); chk("hlt_frozen_cnt", retired_cnt, CNT_EN ? 2 : 0);
        step(3'd1, 4'hF, 64'h0, 4'hF, 64'h0, 0, 0, 1);
        chk("hlt_rst_halted", halted, 0); chk("hlt_rst_cnt", retired_cnt, 0);

        for (int i = 1; i <= 17; i++) begin
            step(3'd1, 4'hF, 64'(i), 4'hF, 64'h0, 0, 0, 0);
            if (i == 16) chk("wrap_15", retired_cnt, CNT_EN ? 15 : 0);
            if (i == 17) chk("wrap_0", retired_cnt, 0);
        end

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] st;
            st = ($urandom_range(0, 39) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
            step(st, 4'($urandom_range(0, 15)), {$urandom, $urandom},
                 ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                 {$urandom, $urandom},
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 59) == 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
